// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t          32-bit architectural data word
//   muldiv_op_t     multiply/divide unit opcode (6 and 7 are reserved)
//   muldiv_state_t  multiply/divide unit sequencer states
//   MULDIV_ITER     number of iterative steps per multiply/divide
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 iteration steps plus a sign-fix cycle
// (33-cycle latency). MTHI/MTLO complete at the accepting edge.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   start, op        request and opcode (accepted only while idle)
//   rs_dat, rt_dat   operand A / operand B
//   cancel           flush: abort the in-flight operation, drop an idle request
//   busy             iterative operation in progress
//   done             one-cycle pulse after HI/LO were written
//   hi, lo           architectural HI/LO registers
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      rs_dat,
  input  word_t      rt_dat,
  input  logic       cancel,
  output logic       busy,
  output logic       done,
  output word_t      hi,
  output word_t      lo
);

  muldiv_state_t state;
  logic [4:0]    cnt;
  logic [63:0]   acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  word_t         a_mag;   // dividend magnitude, kept for the divide-by-zero result
  word_t         b_mag;   // multiplicand / divisor magnitude
  logic          is_div;
  logic          a_neg;   // remainder sign (dividend negative)
  logic          res_neg; // product / quotient sign
  logic          div0;

  // Operand magnitudes and signs at acceptance.
  logic  is_sgn, in_a_neg, in_b_neg, is_iter;
  word_t in_a_mag, in_b_mag;

  always_comb begin
    is_sgn   = (op == MULT) || (op == DIV);
    in_a_neg = is_sgn & rs_dat[31];
    in_b_neg = is_sgn & rt_dat[31];
    in_a_mag = in_a_neg ? (32'd0 - rs_dat) : rs_dat;
    in_b_mag = in_b_neg ? (32'd0 - rt_dat) : rt_dat;
    is_iter  = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  end

  // One iteration step on the shared accumulator.
  logic [32:0] add_sum;
  logic [33:0] diff;
  logic [63:0] acc_step;

  always_comb begin
    add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    // After the left shift the partial remainder is 33 bits wide, so compare
    // with one extra bit to see the borrow.
    diff     = {1'b0, acc[63:31]} - {2'b00, b_mag};
    acc_step = {add_sum, acc[31:1]};
    if (is_div) begin
      if (!diff[33]) acc_step = {diff[31:0], acc[30:0], 1'b1};
      else           acc_step = {acc[62:0], 1'b0};
    end
  end

  // Sign fix-up of the magnitude result.
  logic [63:0] prod;
  word_t       fix_hi, fix_lo;

  always_comb begin
    prod = res_neg ? (64'd0 - acc) : acc;
    if (!is_div) begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end else if (div0) begin
      fix_hi = a_neg ? (32'd0 - a_mag) : a_mag;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = a_neg   ? (32'd0 - acc[63:32]) : acc[63:32];
      fix_lo = res_neg ? (32'd0 - acc[31:0])  : acc[31:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      acc     <= 64'd0;
      a_mag   <= 32'd0;
      b_mag   <= 32'd0;
      is_div  <= 1'b0;
      a_neg   <= 1'b0;
      res_neg <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (is_iter) begin
              acc     <= {32'd0, in_a_mag};
              a_mag   <= in_a_mag;
              b_mag   <= in_b_mag;
              is_div  <= (op == DIV) || (op == DIVU);
              a_neg   <= in_a_neg;
              res_neg <= in_a_neg ^ in_b_neg;
              div0    <= (rt_dat == 32'd0);
              cnt     <= 5'(MULDIV_ITER - 1);
              busy    <= 1'b1;
              state   <= CALC;
            end else if (op == MTHI) begin
              hi   <= rs_dat;
              done <= 1'b1;
            end else if (op == MTLO) begin
              lo   <= rs_dat;
              done <= 1'b1;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operands compared against a plain-arithmetic model of HI/LO.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  muldiv_op_t op = MULT;
  word_t      rs_dat = '0, rt_dat = '0;
  logic       cancel = 1'b0;
  logic       busy, done;
  word_t      hi, lo;

  int checks = 0;
  int errors = 0;
  word_t exp_hi = '0, exp_lo = '0;

  muldiv_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_dat(rs_dat),
    .rt_dat(rt_dat), .cancel(cancel), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference {hi,lo} from the architectural definition.
  function automatic logic [63:0] model(input muldiv_op_t o, input word_t a, input word_t b);
    longint sa, sb, sq, sr;
    logic [63:0] u;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      MULT:  begin sq = sa * sb; res = sq; end
      MULTU: begin u = {32'd0, a} * {32'd0, b}; res = u; end
      DIV:   if (b == 0) res = {a, 32'hFFFF_FFFF};
             else begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      DIVU:  if (b == 0) res = {a, 32'hFFFF_FFFF};
             else res = {a % b, a / b};
      default: res = {exp_hi, exp_lo};
    endcase
    return res;
  endfunction

  // Issue one operation and check latency, pulse shape and HI/LO.
  task automatic run_op(input muldiv_op_t o, input word_t a, input word_t b, input string nm);
    logic [63:0] r;
    int k;
    op = o; rs_dat = a; rt_dat = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (o == MTHI || o == MTLO) begin
      if (o == MTHI) exp_hi = a; else exp_lo = a;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL %s: done=%b busy=%b hi=%h lo=%h, want done=1 busy=0 hi=%h lo=%h",
                 nm, done, busy, hi, lo, exp_hi, exp_lo);
      end
    end else begin
      r = model(o, a, b);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_after_accept: busy=%b want 1", nm, busy);
      end
      k = 0;
      while (k < 40 && done !== 1'b1) begin
        tick();
        k++;
      end
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      checks++;
      if (k != 33 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL %s result: cycles=%0d busy=%b hi=%h lo=%h, want cycles=33 busy=0 hi=%h lo=%h",
                 nm, k, busy, hi, lo, exp_hi, exp_lo);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b want 0 one cycle later", nm, done);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    tick(); tick();
    RST = 1'b0;
    tick();
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_release: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_mult();
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_const: hi=%h lo=%h want 00000001 fffffffe", hi, lo);
    end
    run_op(MULT, -32'sd3, 32'd5, "mult_neg3_x5");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_const: hi=%h lo=%h want ffffffff fffffff1", hi, lo);
    end
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    for (int i = 0; i < 6; i++)
      run_op((i % 2) ? MULTU : MULT, $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_div();
    run_op(DIV, -32'sd7, 32'd2, "div_neg7_2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_const: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      errors++;
      $display("FAIL div_overflow_const: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
    run_op(DIV, -32'sd100, 32'd0, "div_signed_by_zero");
    run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
    for (int i = 0; i < 8; i++) begin
      word_t b;
      b = (i == 5) ? 32'd0 : ((i % 3 == 0) ? ($urandom & 32'hFFFF) : $urandom);
      run_op((i % 2) ? DIVU : DIV, $urandom, b, "div_rand");
    end
  endtask

  task automatic test_busy_start();
    int k;
    op = DIVU; rs_dat = 32'h1234; rt_dat = 32'd0; start = 1'b1;
    tick();
    op = MULT; rs_dat = 32'd7; rt_dat = 32'd9; start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1;                 // ignored: unit is busy
    tick();
    start = 1'b0;
    k = 5;
    while (k < 40 && done !== 1'b1) begin
      tick();
      k++;
    end
    exp_hi = 32'h1234; exp_lo = 32'hFFFF_FFFF;
    checks++;
    if (k != 33 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL busy_start_ignored: cycles=%0d hi=%h lo=%h want 33 00001234 ffffffff", k, hi, lo);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_no_second_op: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_cancel();
    int seen;
    run_op(MTHI, 32'hA5A5_A5A5, 32'd0, "mthi");
    run_op(MTLO, 32'h0BAD_F00D, 32'd0, "mtlo");
    op = MULT; rs_dat = 32'd1234; rt_dat = 32'd5678; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy: busy=%b want 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || hi !== 32'hA5A5_A5A5 || lo !== exp_lo) begin
      errors++;
      $display("FAIL cancel_result: done_pulses=%0d hi=%h lo=%h want 0 a5a5a5a5 %h", seen, hi, lo, exp_lo);
    end
    // cancel with start in idle drops the request
    op = MTLO; rs_dat = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
    tick();
    op = MULT;
    tick();
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== exp_lo || hi !== exp_hi) begin
      errors++;
      $display("FAIL cancel_start_idle: done=%b busy=%b hi=%h lo=%h want 0 0 %h %h",
               done, busy, hi, lo, exp_hi, exp_lo);
    end
    // reserved opcode is ignored
    op = muldiv_op_t'(3'd6); rs_dat = 32'h1111_1111; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== exp_lo || hi !== exp_hi) begin
      errors++;
      $display("FAIL reserved_op: done=%b busy=%b hi=%h lo=%h want 0 0 %h %h",
               done, busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int k;
    op = MULTU; rs_dat = 32'h0001_0000; rt_dat = 32'h0003_0000; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 40 && done !== 1'b1) begin tick(); k++; end
    r = model(MULTU, 32'h0001_0000, 32'h0003_0000);
    exp_hi = r[63:32]; exp_lo = r[31:0];
    checks++;
    if (k != 33 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d hi=%h lo=%h want 33 %h %h", k, hi, lo, exp_hi, exp_lo);
    end
    // new request in the done cycle
    op = DIVU; rs_dat = 32'd1000; rt_dat = 32'd33; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    k = 0;
    while (k < 40 && done !== 1'b1) begin tick(); k++; end
    checks++;
    if (k != 33 || hi !== 32'd10 || lo !== 32'd30) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h want 33 0000000a 0000001e", k, hi, lo);
    end
    exp_hi = 32'd10; exp_lo = 32'd30;
    tick();
  endtask

  task automatic test_async_reset();
    op = MULT; rs_dat = 32'h1234_5678; rt_dat = 32'h9ABC_DEF0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #3 RST = 1'b1;
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    exp_hi = '0; exp_lo = '0;
    tick();
    RST = 1'b0;
    tick();
    run_op(DIVU, 32'd100, 32'd7, "divu_after_reset");
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL divu_after_reset_const: hi=%h lo=%h want 2 14", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_busy_start();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file read ports. It consumes the rs/rt operand words, executes MULT/MULTU/DIV/DIVU over 32 iterations and MTHI/MTLO in one cycle, and holds the architectural HI/LO registers. MFHI/MFLO results return to the register file write port through the normal writeback path.

## Interface
- No parameters; data width fixed at 32 (`word_t`).
- `CLK`  in  1  rising-edge clock
- `RST`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only when the unit is idle
- `op`  in  3  `muldiv_op_t`: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are reserved
- `rs_dat`  in  32  operand A (multiplicand / dividend / MTHI-MTLO source)
- `rt_dat`  in  32  operand B (multiplier / divisor)
- `cancel`  in  1  pipeline flush; aborts the in-flight operation
- `busy`  out  1  iterative operation in progress
- `done`  out  1  one-cycle pulse: HI/LO updated on the preceding edge
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE + `start` + MULT/MULTU/DIV/DIVU:
  - Latch operands. Signed ops latch magnitudes plus sign flags.
  - Load 5-bit counter with 31; go to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on a 64-bit accumulator; counter decrements. Counter 0 → FIX.
- FIX: apply signs and write HI/LO → IDLE.
- Multiply: {hi,lo} = 64-bit product. Signed: negate the magnitude product when operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - Signed: quotient negative when signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) → lo=0x80000000, hi=0.
- Divide by zero (signed or unsigned): lo=0xFFFFFFFF, hi=rs_dat. Still takes full latency.
- MTHI/MTLO in IDLE: write the selected register from rs_dat at the accepting edge. `busy` stays 0.
- Reserved op: `start` ignored, no state change.
- `start` while busy: ignored. Operands are not re-latched.
- `cancel` in CALC or FIX: return to IDLE next edge; HI/LO unchanged; no `done`.
- `cancel` and `start` together in IDLE: cancel wins, request dropped.
- Reset (any time, including mid-operation): hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.

## Timing
- Accepting edge t0 for MULT/DIV-class ops:
  - `busy`=1 from after t0 through t0+33.
  - HI/LO and `done`=1 visible after edge t0+33; `busy` falls at the same edge.
  - Result latency: 33 cycles.
- `done` deasserts at the next edge.
- MTHI/MTLO: register and `done` visible after t0.
- A new `start` may be accepted in the same cycle `done` is high.
- HI/LO read directly from registers; no bypass of an in-progress result.

## Structure
- Add to `cpu_types_pkg`:
  - `muldiv_op_t` (3-bit enum above)
  - `muldiv_state_t` (IDLE/CALC/FIX)
  - constant `MULDIV_ITER = 32`
- Reuse the package's `word_t`.
- Single module with no sub-module. Multiply and divide share the accumulator, counter and sign-fix logic.

## Test plan
- MULTU 0xFFFFFFFF × 2 → after 33 cycles hi=0x00000001, lo=0xFFFFFFFE, single `done` pulse.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed division:
  - DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero, and a start while busy:
  - DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
  - A second `start` during CALC is ignored and the first result is unchanged.
- Cancel and MTHI:
  - MTHI 0xA5A5A5A5, then MULT with `cancel` at cycle 10 → hi stays 0xA5A5A5A5, lo unchanged, no `done`, busy=0 next cycle.
  - `cancel` and `start` together in IDLE → no operation.
- Reset: assert `RST` mid-CALC → hi=lo=0, busy=done=0 immediately (asynchronous). After release, a fresh DIVU 100/7 → lo=14, hi=2 at 33 cycles.
